// File: rtl/multicycle_controller.sv
// Control FSM sequencing a multi-cycle RV32I-subset datapath (fetch, decode, execute, memory, writeback).
// Latency: outputs are combinational from state/IR fields/zero; 2 (illegal) to 5 (lw, jalr) cycles per instruction.
// Backpressure: none; advances every clock, rst low aborts to FETCH and masks every write enable.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_JALRADR  = 4'd12,
    S_JALR     = 4'd13
  } state_t;

  state_t state_q;
  state_t state_d;

  logic is_r, is_i, is_lw, is_sw, is_b, is_jal, is_jalr, is_lui;
  logic r_ok, i_ok, b_ok, instr_ok, b_taken;
  logic [2:0] r_alu, i_alu, b_alu;

  // Only func7[5] distinguishes add from sub; the remaining bits are don't-care.
  logic unused_func7;
  assign unused_func7 = &{1'b0, func7[6], func7[4:0]};

  assign is_r    = (opcode == OP_R);
  assign is_i    = (opcode == OP_I);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_b    = (opcode == OP_B);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);
  assign is_lui  = (opcode == OP_LUI);

  // R-type and I-type ALU operation decode, with func3 legality.
  always_comb begin
    r_alu = ALU_ADD;
    i_alu = ALU_ADD;
    r_ok  = 1'b1;
    i_ok  = 1'b1;
    case (func3)
      3'b000: begin
        r_alu = func7[5] ? ALU_SUB : ALU_ADD;
        i_alu = ALU_ADD;
      end
      3'b111: begin
        r_alu = ALU_AND;
        i_alu = ALU_AND;
      end
      3'b110: begin
        r_alu = ALU_OR;
        i_alu = ALU_OR;
      end
      3'b010: begin
        r_alu = ALU_SLT;
        i_alu = ALU_SLT;
      end
      default: begin
        r_ok = 1'b0;
        i_ok = 1'b0;
      end
    endcase
  end

  // Branch compare op and taken condition; blt/bge reuse slt and test its zero result.
  always_comb begin
    b_alu   = ALU_SUB;
    b_ok    = 1'b1;
    b_taken = 1'b0;
    case (func3)
      3'b000: b_taken = zero;
      3'b001: b_taken = ~zero;
      3'b100: begin
        b_alu   = ALU_SLT;
        b_taken = ~zero;
      end
      3'b101: begin
        b_alu   = ALU_SLT;
        b_taken = zero;
      end
      default: b_ok = 1'b0;
    endcase
  end

  assign instr_ok = is_lw | is_sw | is_jal | is_jalr | is_lui
                  | (is_r & r_ok) | (is_i & i_ok) | (is_b & b_ok);

  // Immediate format follows the opcode in every state.
  always_comb begin
    ImmSrc = 3'b000;
    if (is_sw)      ImmSrc = 3'b001;
    else if (is_b)   ImmSrc = 3'b010;
    else if (is_jal) ImmSrc = 3'b011;
    else if (is_lui) ImmSrc = 3'b100;
  end

  // State register with synchronous active-low reset to FETCH.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  assign state = state_q;

  // Next-state and per-state control; reset masks enables and shows FETCH selects.
  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUControl = ALU_ADD;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        PCWrite   = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (!instr_ok) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (is_lw || is_sw) state_d = S_MEMADR;
        else if (is_r)               state_d = S_EXECR;
        else if (is_i)               state_d = S_EXECI;
        else if (is_b)               state_d = S_BRANCH;
        else if (is_jal)             state_d = S_JAL;
        else if (is_lui)             state_d = S_LUI;
        else                         state_d = S_JALRADR;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = is_sw ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = r_alu;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = i_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = b_alu;
        PCWrite    = b_taken;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL, S_JALR: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc  = RES_IMM;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JALRADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = S_JALR;
      end
      default: state_d = S_FETCH;
    endcase
    if (!rst) begin
      state_d    = S_FETCH;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = RES_ALURES;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_FOUR;
      ALUControl = ALU_ADD;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule
